// File: rtl/design_reset_sequencer_pkg.sv
// design_reset_sequencer_pkg
// Shared definitions for the design reset sequencer:
//   - design index constants (bit positions in the enable/reset vectors)
//   - default vector width
//   - sequencer FSM state encoding
package design_reset_sequencer_pkg;

  localparam int NUM_DESIGNS_DEF = 5;

  localparam int DESIGN_BLINKER  = 0;
  localparam int DESIGN_SID      = 1;
  localparam int DESIGN_SN76489  = 2;
  localparam int DESIGN_QCPU     = 3;
  localparam int DESIGN_MC14500  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/design_reset_sequencer_if.sv
// design_reset_sequencer_if
// Bundles the enable inputs, reset outputs and status lines of the
// sequencer.
//   design_en_i   : run-enables from the design multiplexer (async, may glitch)
//   design_rst_no : active-low resets to the design macros
//   active_idx_o  : index of the released design, 0 when none
//   running_o     : sequencer in RUN
//   holding_o     : sequencer in HOLD
//   err_multi_o   : filtered enable vector has more than one bit set
//   state_o       : current FSM state, for observation only
// Modports: master = the sequencer, slave = the surrounding logic.
interface design_reset_sequencer_if
  import design_reset_sequencer_pkg::*;
#(
  parameter int NUM_DESIGNS = NUM_DESIGNS_DEF
);
  logic [NUM_DESIGNS-1:0] design_en_i;
  logic [NUM_DESIGNS-1:0] design_rst_no;
  logic [2:0]             active_idx_o;
  logic                   running_o;
  logic                   holding_o;
  logic                   err_multi_o;
  state_t                 state_o;

  modport master (
    input  design_en_i,
    output design_rst_no, active_idx_o, running_o, holding_o, err_multi_o, state_o
  );

  modport slave (
    output design_en_i,
    input  design_rst_no, active_idx_o, running_o, holding_o, err_multi_o, state_o
  );
endinterface

// File: rtl/design_reset_sequencer_enable_sync_filter.sv
// design_reset_sequencer_enable_sync_filter
// Two-flop synchroniser followed by a whole-vector stability filter.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : raw enable vector (asynchronous to i_clk)
//   o_s2           : synchronised enable vector
//   o_filt         : last synchronised pattern that stayed unchanged for
//                    FILTER_CYCLES consecutive checks
module design_reset_sequencer_enable_sync_filter #(
  parameter int NUM_DESIGNS   = 5,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NUM_DESIGNS-1:0] i_en,
  output logic [NUM_DESIGNS-1:0] o_s2,
  output logic [NUM_DESIGNS-1:0] o_filt
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [NUM_DESIGNS-1:0] r_s1;
  logic [NUM_DESIGNS-1:0] r_s2;
  logic [NUM_DESIGNS-1:0] r_cand;
  logic [NUM_DESIGNS-1:0] r_filt;
  logic [CW-1:0]          r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_cand <= '0;
      r_filt <= '0;
      r_cnt  <= '0;
    end else begin
      r_s1 <= i_en;
      r_s2 <= r_s1;
      // Any change restarts the stability count; once the count saturates
      // the candidate is (re)published and the counter simply holds.
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_cand;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_s2   = r_s2;
  assign o_filt = r_filt;

endmodule

// File: rtl/design_reset_sequencer.sv
// design_reset_sequencer
// Turns per-design run-enables into active-low design resets with
// break-before-make: at most one design is out of reset at any time.
// Reset assertion is fast (driven by the synchronised enables), release is
// slow (filtered enables plus a MIN_ASSERT-cycle hold in reset).
//   wb_clk_i  : system clock
//   wb_rst_ni : asynchronous active-low reset
//   bus       : enable inputs, reset outputs and status (master modport)
// Handshake: none; design_en_i is a level input sampled every cycle and all
// outputs are levels derived from registers.
module design_reset_sequencer
  import design_reset_sequencer_pkg::*;
#(
  parameter int NUM_DESIGNS   = NUM_DESIGNS_DEF,
  parameter int FILTER_CYCLES = 4,
  parameter int MIN_ASSERT    = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  design_reset_sequencer_if.master  bus
);

  localparam int HW = (MIN_ASSERT > 1) ? $clog2(MIN_ASSERT) : 1;
  localparam logic [HW-1:0] HCNT_LAST = HW'(MIN_ASSERT - 1);
  localparam logic [NUM_DESIGNS-1:0] ONE_VEC = {{(NUM_DESIGNS-1){1'b0}}, 1'b1};

  function automatic logic [3:0] popcount(input logic [NUM_DESIGNS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_DESIGNS; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Lowest set bit; only used on one-hot vectors.
  function automatic logic [2:0] first_index(input logic [NUM_DESIGNS-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NUM_DESIGNS - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [NUM_DESIGNS-1:0] w_s2;
  logic [NUM_DESIGNS-1:0] w_filt;
  logic [NUM_DESIGNS-1:0] w_sel_vec;
  logic                   w_filt_onehot;

  state_t                 r_state;
  logic [2:0]             r_sel;
  logic [HW-1:0]          r_hcnt;
  logic [NUM_DESIGNS-1:0] r_rst;
  logic                   r_err;

  state_t                 w_state_nxt;
  logic [2:0]             w_sel_nxt;
  logic [HW-1:0]          w_hcnt_nxt;
  logic [NUM_DESIGNS-1:0] w_rst_nxt;

  design_reset_sequencer_enable_sync_filter #(
    .NUM_DESIGNS   (NUM_DESIGNS),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_sync_filter (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_ni),
    .i_en    (bus.design_en_i),
    .o_s2    (w_s2),
    .o_filt  (w_filt)
  );

  assign w_sel_vec     = ONE_VEC << r_sel;
  assign w_filt_onehot = (popcount(w_filt) == 4'd1);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_hcnt  <= '0;
      r_rst   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_rst   <= w_rst_nxt;
      r_err   <= (popcount(w_filt) > 4'd1);
    end
  end

  // Entry into HOLD needs the filtered pattern; staying in HOLD/RUN only
  // needs the synchronised vector, so any disturbance drops back to IDLE
  // (and re-asserts the reset) without waiting for the filter.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_hcnt_nxt  = r_hcnt;
    w_rst_nxt   = r_rst;
    case (r_state)
      ST_IDLE: begin
        if (w_filt_onehot && (w_s2 == w_filt)) begin
          w_sel_nxt   = first_index(w_filt);
          w_hcnt_nxt  = '0;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_s2 != w_sel_vec) begin
          w_state_nxt = ST_IDLE;
        end else if (r_hcnt == HCNT_LAST) begin
          w_state_nxt = ST_RUN;
          w_rst_nxt   = w_sel_vec;
        end else begin
          w_hcnt_nxt = r_hcnt + HW'(1);
        end
      end
      ST_RUN: begin
        if (w_s2 != w_sel_vec) begin
          w_state_nxt = ST_IDLE;
          w_rst_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rst_nxt   = '0;
      end
    endcase
  end

  assign bus.design_rst_no = r_rst;
  assign bus.active_idx_o  = (r_state == ST_RUN) ? r_sel : 3'd0;
  assign bus.running_o     = (r_state == ST_RUN);
  assign bus.holding_o     = (r_state == ST_HOLD);
  assign bus.err_multi_o   = r_err;
  assign bus.state_o       = r_state;

endmodule
